// File: rtl/hwpe_cfg_initiator.sv
// hwpe_cfg_initiator
//   Queues register-access commands and issues them one at a time on an HWPE
//   periph-style configuration port. Each granted request is tagged with an
//   incrementing ID. Exactly one response is expected per granted request,
//   and responses arrive in grant order. Each response is returned to the
//   command side as a single-cycle pulse.
//
// Handshakes:
//   cmd side    : a command transfers on a rising edge where
//                 cmd_valid_i && cmd_ready_o.
//   periph side : a request transfers on a rising edge where
//                 periph_req_o && periph_gnt_i. Once raised, req and all
//                 request fields stay stable until that edge.
//   response    : periph_r_valid_i is accepted on every cycle. There is no
//                 back-pressure. rsp_valid_o is a pulse and has no ready.
//
// Ports:
//   clk, rst_n               clock and asynchronous active-low reset
//   cmd_*                    command input (wen=1 read, 0 write), FIFO-buffered
//   periph_req/add/wen/be/data/id, periph_gnt_i   request channel
//   periph_r_valid/r_data/r_id                    response channel
//   rsp_valid/rdata/wen      completed-command pulse
//   err_o / err_clr_i        sticky protocol error (ID mismatch, spurious rsp)
//   busy_o                   FIFO non-empty or requests outstanding
module hwpe_cfg_initiator #(
    parameter int ID_WIDTH        = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_wen_i,
    input  logic [31:0]         cmd_add_i,
    input  logic [31:0]         cmd_wdata_i,
    input  logic [3:0]          cmd_be_i,
    output logic                periph_req_o,
    output logic [31:0]         periph_add_o,
    output logic                periph_wen_o,
    output logic [3:0]          periph_be_o,
    output logic [31:0]         periph_data_o,
    output logic [ID_WIDTH-1:0] periph_id_o,
    input  logic                periph_gnt_i,
    input  logic                periph_r_valid_i,
    input  logic [31:0]         periph_r_data_i,
    input  logic [ID_WIDTH-1:0] periph_r_id_i,
    output logic                rsp_valid_o,
    output logic [31:0]         rsp_rdata_o,
    output logic                rsp_wen_o,
    output logic                err_o,
    input  logic                err_clr_i,
    output logic                busy_o
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    // The expected-response queue is sized for the largest legal
    // MAX_OUTSTANDING. Occupancy is still bounded by MAX_OUTSTANDING.
    localparam int QD = 4;

    typedef struct packed {
        logic        wen;
        logic [31:0] add;
        logic [31:0] data;
        logic [3:0]  be;
    } cmd_t;

    cmd_t          fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_full, fifo_empty;
    logic          push, pop;
    cmd_t          head;

    logic [ID_WIDTH-1:0] exp_id_q  [QD];
    logic                exp_wen_q [QD];
    logic [1:0]          eq_wr, eq_rd;
    logic [2:0]          out_cnt;
    logic [ID_WIDTH-1:0] id_cnt;

    logic rsp_fire, spurious, id_err, new_err;

    assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign cmd_ready_o = !fifo_full;
    assign push = cmd_valid_i && !fifo_full;

    // req depends only on registered state. Outstanding can only fall while
    // req waits for grant, so req cannot drop before it is granted.
    assign periph_req_o = !fifo_empty && (out_cnt < 3'(MAX_OUTSTANDING));
    assign pop = periph_req_o && periph_gnt_i;

    // FIFO storage is not reset. The fields are forced to zero while the
    // FIFO is empty, so stale or uninitialised entries are never visible.
    assign head          = fifo_mem[rd_ptr];
    assign periph_add_o  = fifo_empty ? 32'h0 : head.add;
    assign periph_wen_o  = fifo_empty ? 1'b0  : head.wen;
    assign periph_be_o   = fifo_empty ? 4'h0  : head.be;
    assign periph_data_o = fifo_empty ? 32'h0 : head.data;
    assign periph_id_o   = id_cnt;

    assign rsp_fire = periph_r_valid_i && (out_cnt != '0);
    assign spurious = periph_r_valid_i && (out_cnt == '0);
    assign id_err   = rsp_fire && (periph_r_id_i != exp_id_q[eq_rd]);
    assign new_err  = id_err || spurious;

    assign busy_o = !fifo_empty || (out_cnt != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{wen: cmd_wen_i, add: cmd_add_i,
                                  data: cmd_wdata_i, be: cmd_be_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eq_wr   <= '0;
            eq_rd   <= '0;
            out_cnt <= '0;
            id_cnt  <= '0;
            for (int i = 0; i < QD; i++) begin
                exp_id_q[i]  <= '0;
                exp_wen_q[i] <= 1'b0;
            end
        end else begin
            if (pop) begin
                exp_id_q[eq_wr]  <= id_cnt;
                exp_wen_q[eq_wr] <= head.wen;
                eq_wr            <= eq_wr + 2'd1;
                id_cnt           <= id_cnt + ID_WIDTH'(1);
            end
            if (rsp_fire) eq_rd <= eq_rd + 2'd1;
            out_cnt <= out_cnt + 3'(pop) - 3'(rsp_fire);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_wen_o   <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            rsp_valid_o <= rsp_fire;
            if (rsp_fire) begin
                rsp_rdata_o <= periph_r_data_i;
                rsp_wen_o   <= exp_wen_q[eq_rd];
            end
            // A new error wins over a clear in the same cycle.
            if (new_err)        err_o <= 1'b1;
            else if (err_clr_i) err_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hwpe_cfg_initiator.sv
module tb_hwpe_cfg_initiator;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid_i, cmd_ready_o, cmd_wen_i;
  logic [31:0] cmd_add_i, cmd_wdata_i;
  logic [3:0]  cmd_be_i;
  logic        periph_req_o, periph_wen_o;
  logic [31:0] periph_add_o, periph_data_o;
  logic [3:0]  periph_be_o;
  logic [7:0]  periph_id_o;
  logic        periph_gnt_i, periph_r_valid_i;
  logic [31:0] periph_r_data_i;
  logic [7:0]  periph_r_id_i;
  logic        rsp_valid_o, rsp_wen_o, err_o, err_clr_i, busy_o;
  logic [31:0] rsp_rdata_o;

  int n_cmp;
  int n_bad;

  hwpe_cfg_initiator #(.ID_WIDTH(8), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wen_i(cmd_wen_i),
    .cmd_add_i(cmd_add_i), .cmd_wdata_i(cmd_wdata_i), .cmd_be_i(cmd_be_i),
    .periph_req_o(periph_req_o), .periph_add_o(periph_add_o),
    .periph_wen_o(periph_wen_o), .periph_be_o(periph_be_o),
    .periph_data_o(periph_data_o), .periph_id_o(periph_id_o),
    .periph_gnt_i(periph_gnt_i), .periph_r_valid_i(periph_r_valid_i),
    .periph_r_data_i(periph_r_data_i), .periph_r_id_i(periph_r_id_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_wen_o(rsp_wen_o),
    .err_o(err_o), .err_clr_i(err_clr_i), .busy_o(busy_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic offer_cmd(input logic wen, input logic [31:0] add, input logic [31:0] data);
    cmd_valid_i = 1'b1;
    cmd_wen_i   = wen;
    cmd_add_i   = add;
    cmd_wdata_i = data;
    cmd_be_i    = 4'hF;
  endtask

  task automatic respond(input logic [7:0] id, input logic [31:0] data);
    periph_r_valid_i = 1'b1;
    periph_r_id_i    = id;
    periph_r_data_i  = data;
  endtask

  // Single read: accept, grant, respond. Checks the issued ID and returned data.
  task automatic do_read(input logic [7:0] eid, input logic [31:0] rd);
    offer_cmd(1'b1, 32'h40, 32'h0);
    tick();
    cmd_valid_i = 1'b0;
    check_val("rd_req", 32'(periph_req_o), 32'd1);
    check_val("rd_id", 32'(periph_id_o), 32'(eid));
    periph_gnt_i = 1'b1;
    tick();
    periph_gnt_i = 1'b0;
    respond(eid, rd);
    tick();
    periph_r_valid_i = 1'b0;
    check_val("rd_data", rsp_rdata_o, rd);
  endtask

  initial begin
    logic [7:0] eid;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    cmd_valid_i = 1'b0; cmd_wen_i = 1'b0; cmd_add_i = '0; cmd_wdata_i = '0; cmd_be_i = '0;
    periph_gnt_i = 1'b0; periph_r_valid_i = 1'b0; periph_r_data_i = '0; periph_r_id_i = '0;
    err_clr_i = 1'b0;
    tick(); tick();

    // reset state
    check_val("rst_ready", 32'(cmd_ready_o), 32'd1);
    check_val("rst_req", 32'(periph_req_o), 32'd0);
    check_val("rst_busy", 32'(busy_o), 32'd0);
    check_val("rst_err", 32'(err_o), 32'd0);
    check_val("rst_rsp", 32'(rsp_valid_o), 32'd0);
    check_val("rst_add", periph_add_o, 32'h0);
    check_val("rst_id", 32'(periph_id_o), 32'd0);
    rst_n = 1'b1;
    tick();

    // single write with immediate grant
    offer_cmd(1'b0, 32'h10, 32'hDEADBEEF);
    periph_gnt_i = 1'b1;
    check_val("w_req_early", 32'(periph_req_o), 32'd0);
    tick();
    cmd_valid_i = 1'b0;
    check_val("w_req", 32'(periph_req_o), 32'd1);
    check_val("w_add", periph_add_o, 32'h10);
    check_val("w_data", periph_data_o, 32'hDEADBEEF);
    check_val("w_wen", 32'(periph_wen_o), 32'd0);
    check_val("w_be", 32'(periph_be_o), 32'hF);
    check_val("w_id", 32'(periph_id_o), 32'd0);
    tick();
    periph_gnt_i = 1'b0;
    check_val("w_req_after", 32'(periph_req_o), 32'd0);
    check_val("w_busy", 32'(busy_o), 32'd1);
    check_val("w_id_next", 32'(periph_id_o), 32'd1);
    respond(8'd0, 32'h0);
    tick();
    periph_r_valid_i = 1'b0;
    check_val("w_rsp_valid", 32'(rsp_valid_o), 32'd1);
    check_val("w_rsp_wen", 32'(rsp_wen_o), 32'd0);
    tick();
    check_val("w_rsp_pulse", 32'(rsp_valid_o), 32'd0);
    check_val("w_idle", 32'(busy_o), 32'd0);

    // five back-to-back commands, grant withheld
    for (int i = 0; i < 5; i++) begin
      offer_cmd(1'b0, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
      check_val("f_ready", 32'(cmd_ready_o), (i < 4) ? 32'd1 : 32'd0);
      if (i >= 1) begin
        check_val("f_req", 32'(periph_req_o), 32'd1);
        check_val("f_add_hold", periph_add_o, 32'h100);
        check_val("f_data_hold", periph_data_o, 32'hA0);
      end
      if (i < 4) tick();
    end
    tick();
    check_val("f_full_ready", 32'(cmd_ready_o), 32'd0);
    check_val("f_full_add", periph_add_o, 32'h100);
    // grant while full with a fifth command still offered
    periph_gnt_i = 1'b1;
    tick();
    check_val("f_pop_ready", 32'(cmd_ready_o), 32'd1);
    check_val("f_pop_add", periph_add_o, 32'h104);
    check_val("f_pop_id", 32'(periph_id_o), 32'd2);
    tick();
    cmd_valid_i = 1'b0;
    // two outstanding: req drops although grant stays high
    check_val("o_req_max", 32'(periph_req_o), 32'd0);
    check_val("o_id", 32'(periph_id_o), 32'd3);
    tick();
    check_val("o_req_hold", 32'(periph_req_o), 32'd0);
    respond(8'd1, 32'h11111111);
    tick();
    periph_r_valid_i = 1'b0;
    check_val("o_req_back", 32'(periph_req_o), 32'd1);
    check_val("o_rsp_valid", 32'(rsp_valid_o), 32'd1);
    check_val("o_rsp_data", rsp_rdata_o, 32'h11111111);
    check_val("o_add", periph_add_o, 32'h108);
    // grant and response in the same cycle: outstanding stays at 1
    respond(8'd2, 32'h22222222);
    tick();
    check_val("s_rsp_data", rsp_rdata_o, 32'h22222222);
    check_val("s_req", 32'(periph_req_o), 32'd1);
    check_val("s_add", periph_add_o, 32'h10C);
    check_val("s_id", 32'(periph_id_o), 32'd4);
    respond(8'd3, 32'h33333333);
    tick();
    check_val("s2_rsp_data", rsp_rdata_o, 32'h33333333);
    check_val("s2_add", periph_add_o, 32'h110);
    check_val("s2_data", periph_data_o, 32'hA4);
    check_val("s2_id", 32'(periph_id_o), 32'd5);
    respond(8'd4, 32'h44444444);
    tick();
    periph_gnt_i = 1'b0;
    check_val("s3_req", 32'(periph_req_o), 32'd0);
    check_val("s3_busy", 32'(busy_o), 32'd1);
    check_val("s3_rsp_data", rsp_rdata_o, 32'h44444444);
    respond(8'd5, 32'h55555555);
    tick();
    periph_r_valid_i = 1'b0;
    check_val("s4_rsp_data", rsp_rdata_o, 32'h55555555);
    check_val("s4_busy", 32'(busy_o), 32'd0);
    check_val("s4_err", 32'(err_o), 32'd0);
    tick();
    check_val("s4_rsp_pulse", 32'(rsp_valid_o), 32'd0);

    // ID mismatch
    offer_cmd(1'b1, 32'h20, 32'h0);
    tick();
    cmd_valid_i = 1'b0;
    periph_gnt_i = 1'b1;
    check_val("m_id", 32'(periph_id_o), 32'd6);
    check_val("m_wen", 32'(periph_wen_o), 32'd1);
    tick();
    periph_gnt_i = 1'b0;
    respond(8'd9, 32'h0000CAFE);
    tick();
    periph_r_valid_i = 1'b0;
    check_val("m_err", 32'(err_o), 32'd1);
    check_val("m_rsp_valid", 32'(rsp_valid_o), 32'd1);
    check_val("m_rsp_wen", 32'(rsp_wen_o), 32'd1);
    check_val("m_rsp_data", rsp_rdata_o, 32'h0000CAFE);
    check_val("m_busy", 32'(busy_o), 32'd0);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check_val("m_err_clr", 32'(err_o), 32'd0);
    // spurious response together with a clear: the error wins
    respond(8'd0, 32'h12345678);
    err_clr_i = 1'b1;
    tick();
    periph_r_valid_i = 1'b0;
    err_clr_i = 1'b0;
    check_val("p_err", 32'(err_o), 32'd1);
    check_val("p_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check_val("p_busy", 32'(busy_o), 32'd0);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check_val("p_err_clr", 32'(err_o), 32'd0);

    // ID wrap: 260 reads starting at ID 7 cover 255 -> 0
    eid = 8'd7;
    for (int n = 0; n < 260; n++) begin
      do_read(eid, 32'hBEEF0000 + 32'(n));
      eid = eid + 8'd1;
    end
    check_val("wrap_id", 32'(periph_id_o), 32'd11);
    check_val("wrap_err", 32'(err_o), 32'd0);

    // reset with two outstanding, then a late response
    periph_gnt_i = 1'b1;
    offer_cmd(1'b0, 32'h30, 32'h1);
    tick();
    offer_cmd(1'b0, 32'h34, 32'h2);
    tick();
    cmd_valid_i = 1'b0;
    tick();
    periph_gnt_i = 1'b0;
    check_val("r_req_max", 32'(periph_req_o), 32'd0);
    check_val("r_busy", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("r_ready", 32'(cmd_ready_o), 32'd1);
    check_val("r_busy0", 32'(busy_o), 32'd0);
    check_val("r_req0", 32'(periph_req_o), 32'd0);
    check_val("r_id0", 32'(periph_id_o), 32'd0);
    check_val("r_rdata0", rsp_rdata_o, 32'h0);
    check_val("r_add0", periph_add_o, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    respond(8'd11, 32'h77777777);
    tick();
    periph_r_valid_i = 1'b0;
    check_val("r_spur_err", 32'(err_o), 32'd1);
    check_val("r_spur_rsp", 32'(rsp_valid_o), 32'd0);
    check_val("r_spur_busy", 32'(busy_o), 32'd0);
    check_val("r_spur_rdata", rsp_rdata_o, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
